// File: rtl/btn_cond_pkg.sv
// Shared timing constants for the button conditioner, derived from the 25 MHz video clock.
package btn_cond_pkg;

    localparam int CLK_HZ                  = 25_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEFAULT_REPEAT_DELAY    = CLK_HZ / 2;    // 0.5 s
    localparam int DEFAULT_REPEAT_PERIOD   = CLK_HZ / 10;   // 0.1 s
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int MAX_NUM_BTN             = 16;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw levels in, debounced level and event pulses out.
interface btn_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_i;
    logic [NUM_BTN-1:0] level_o;
    logic [NUM_BTN-1:0] press_o;
    logic [NUM_BTN-1:0] release_o;
    logic [NUM_BTN-1:0] repeat_o;

    modport master (
        output btn_i,
        input  level_o, press_o, release_o, repeat_o
    );

    modport slave (
        input  btn_i,
        output level_o, press_o, release_o, repeat_o
    );
endinterface

// File: rtl/btn_cond_channel.sv
// One button channel: synchroniser, debounce counter, press/release edges and
// optional autorepeat (enabled by defining BTN_CONDITIONER_AUTOREPEAT_EN).
module btn_cond_channel
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_cond_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_cond_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_cond_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any
    // agreement in between restarts the count.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_bit == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_bit;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(max_of(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;
    logic             repeat_q, repeat_d;
    logic [RPT_W-1:0] rpt_limit;

    // Counter is 0 in the press cycle; the first pulse uses the long delay,
    // later ones the short period. Gating on level_d keeps the release cycle quiet.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        repeat_d    = 1'b0;
        rpt_limit   = rpt_armed_q ? RPT_NEXT : RPT_FIRST;
        if (!level_q || !level_d) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (rpt_cnt_q == rpt_limit) begin
            repeat_d    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
            repeat_q    <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-button conditioner: NUM_BTN independent debounced channels with
// press/release pulses; autorepeat enabled by defining BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    btn_conditioner_if.slave   bus
);

    if (NUM_BTN < 1 || NUM_BTN > MAX_NUM_BTN) begin : g_bad_num_btn
        $error("btn_conditioner: NUM_BTN must be in 1..16");
    end

    // The interface instance must be built with the same NUM_BTN.
    for (genvar n = 0; n < NUM_BTN; n++) begin : g_ch
        btn_cond_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_i     (bus.btn_i[n]),
            .level_o   (bus.level_o[n]),
            .press_o   (bus.press_o[n]),
            .release_o (bus.release_o[n]),
            .repeat_o  (bus.repeat_o[n])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing: 3 channels,
// 2 sync stages, debounce 4, repeat delay 10, repeat period 3.
module tb_btn_conditioner;

    localparam int NUM_BTN = 3;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    btn_conditioner_if #(.NUM_BTN(NUM_BTN)) bus ();

    btn_conditioner #(
        .NUM_BTN         (NUM_BTN),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic expd);
        n_checks++;
        assert (obs === expd) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int c = 0; c < NUM_BTN; c++) begin
            check($sformatf("%s_level%0d", tag, c),   bus.level_o[c],   1'b0);
            check($sformatf("%s_press%0d", tag, c),   bus.press_o[c],   1'b0);
            check($sformatf("%s_release%0d", tag, c), bus.release_o[c], 1'b0);
            check($sformatf("%s_repeat%0d", tag, c),  bus.repeat_o[c],  1'b0);
        end
    endtask

    logic chat [6];

    initial begin
        reset     = 1'b1;
        bus.btn_i = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Hold button 0 from edge 0, release before edge 23.
        // Level rises after edge 5 and falls after edge 28.
        for (int i = 0; i < 36; i++) begin
            bus.btn_i[0] = (i < 23);
            tick();
            check($sformatf("a_level0@%0d", i),   bus.level_o[0],   (i >= 5 && i < 28));
            check($sformatf("a_press0@%0d", i),   bus.press_o[0],   (i == 5));
            check($sformatf("a_release0@%0d", i), bus.release_o[0], (i == 28));
            check($sformatf("a_repeat0@%0d", i),  bus.repeat_o[0],
                  AR_EN && i >= 15 && i < 28 && ((i - 15) % 3 == 0));
            check($sformatf("a_level1@%0d", i), bus.level_o[1], 1'b0);
            check($sformatf("a_level2@%0d", i), bus.level_o[2], 1'b0);
        end

        // Three-cycle pulse on button 1 is one short of the debounce length.
        for (int i = 0; i < 12; i++) begin
            bus.btn_i[1] = (i < 3);
            tick();
            check($sformatf("b_level1@%0d", i),   bus.level_o[1],   1'b0);
            check($sformatf("b_press1@%0d", i),   bus.press_o[1],   1'b0);
            check($sformatf("b_release1@%0d", i), bus.release_o[1], 1'b0);
        end

        // Chatter on button 2: last 0 at edge 1, stable 1 from edge 2 -> level after edge 7.
        chat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            bus.btn_i[2] = (i < 6) ? chat[i] : 1'b1;
            tick();
            check($sformatf("c_level2@%0d", i),   bus.level_o[2],   (i >= 7));
            check($sformatf("c_press2@%0d", i),   bus.press_o[2],   (i == 7));
            check($sformatf("c_release2@%0d", i), bus.release_o[2], 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            bus.btn_i[2] = 1'b0;
            tick();
            check($sformatf("c2_level2@%0d", i),   bus.level_o[2],   (i < 5));
            check($sformatf("c2_release2@%0d", i), bus.release_o[2], (i == 5));
            check($sformatf("c2_press2@%0d", i),   bus.press_o[2],   1'b0);
        end

        // Reset mid-debounce with button 0 held; a fresh press follows.
        bus.btn_i[0] = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_all_zero("d_rst");
        reset = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            tick();
            check($sformatf("d_level0@%0d", j),   bus.level_o[0],   (j >= 6));
            check($sformatf("d_press0@%0d", j),   bus.press_o[0],   (j == 6));
            check($sformatf("d_release0@%0d", j), bus.release_o[0], 1'b0);
        end

        // Reset while held (and counting towards a repeat): no release pulse, re-press.
        reset = 1'b1;
        tick();
        check_all_zero("e_rst");
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check($sformatf("e_level0@%0d", j),   bus.level_o[0],   (j >= 6));
            check($sformatf("e_press0@%0d", j),   bus.press_o[0],   (j == 6));
            check($sformatf("e_release0@%0d", j), bus.release_o[0], 1'b0);
            check($sformatf("e_repeat0@%0d", j),  bus.repeat_o[0],  1'b0);
        end

        bus.btn_i = '0;
        repeat (8) tick();
        check("f_level0_idle", bus.level_o[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
